// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES byte-stream controller.
//   state_t      : controller FSM states
//   shift_mode_t : operating mode of aes_byte_shifter
package aes_stream_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    GAP,
    LOAD,
    WAIT,
    CAPT,
    DONE
  } state_t;

  // A left shift by one byte serves both directions: the MSB byte leaves
  // (shift-out) while the fill byte enters at the LSB (shift-in).
  typedef enum logic [1:0] {
    SH_HOLD,
    SH_LOAD,
    SH_SHIFT
  } shift_mode_t;

endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit register with parallel load and byte-wise left shift.
//   clk, rst : clock, async active-high reset (clears q)
//   mode     : hold / parallel load / shift left one byte
//   load_val : parallel load value
//   fill     : byte entering at the LSB on a shift
//   q        : register contents; q[127:120] is the next byte out
module aes_byte_shifter
  import aes_stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  shift_mode_t        mode,
  input  logic [BLOCK_W-1:0] load_val,
  input  logic [BYTE_W-1:0]  fill,
  output logic [BLOCK_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (mode)
        SH_LOAD:  q <= load_val;
        SH_SHIFT: q <= {q[BLOCK_W-BYTE_W-1:0], fill};
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/aes_byte_stream_ctrl.sv
// Feeds the 8-bit serial AES core from 128-bit key/plaintext registers and
// reassembles its 16 serial output bytes into a 128-bit ciphertext.
//   clk, rst        : clock, async active-high reset
//   start           : one-cycle request, honoured only in IDLE
//   key, pt         : cipher key / plaintext, MSB byte sent first
//   busy, done, err : status; done is a one-cycle pulse, err is sticky
//   ct              : ciphertext, first captured byte lands in ct[127:120]
//   core_rst        : core reset, held high whenever the controller is idle
//   core_key        : key byte stream to the core
//   core_din        : plaintext byte stream to the core
//   core_dout       : ciphertext byte stream from the core
//   core_vld        : core output valid
module aes_byte_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int unsigned LOAD_DELAY = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] pt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BLOCK_W-1:0] ct,
  output logic               core_rst,
  output logic [BYTE_W-1:0]  core_key,
  output logic [BYTE_W-1:0]  core_din,
  input  logic [BYTE_W-1:0]  core_dout,
  input  logic               core_vld
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BLOCK_W-1:0] key_q;
  logic [BLOCK_W-1:0] pt_q;
  shift_mode_t        src_mode;
  shift_mode_t        ct_mode;
  logic               accept;
  logic               gap_end;
  logic               load_last;
  logic               wait_to;
  logic               capt_last;

  // State-exit decodes and shifter control.
  always_comb begin
    accept    = (state == IDLE) && start;
    // A zero LOAD_DELAY still leaves one GAP cycle.
    gap_end   = (state == GAP) && ((32'(cnt) + 32'd1) >= LOAD_DELAY);
    load_last = (state == LOAD) && (cnt == CNT_W'(BLOCK_BYTES - 1));
    wait_to   = (state == WAIT) && !core_vld && (cnt == CNT_W'(TIMEOUT - 1));
    // Byte 0 is taken in WAIT, so CAPT covers the remaining 15.
    capt_last = (state == CAPT) && (cnt == CNT_W'(BLOCK_BYTES - 2));

    src_mode = SH_HOLD;
    if (accept) begin
      src_mode = SH_LOAD;
    end else if (gap_end || ((state == LOAD) && !load_last)) begin
      src_mode = SH_SHIFT;
    end

    ct_mode = SH_HOLD;
    if (accept) begin
      ct_mode = SH_LOAD;
    end else if (((state == WAIT) && core_vld) || (state == CAPT)) begin
      ct_mode = SH_SHIFT;
    end
  end

  aes_byte_shifter u_key_sr (
    .clk      (clk),
    .rst      (rst),
    .mode     (src_mode),
    .load_val (key),
    .fill     ('0),
    .q        (key_q)
  );

  aes_byte_shifter u_pt_sr (
    .clk      (clk),
    .rst      (rst),
    .mode     (src_mode),
    .load_val (pt),
    .fill     ('0),
    .q        (pt_q)
  );

  // ct clears to zero on an accepted start and fills from the LSB side.
  aes_byte_shifter u_ct_sr (
    .clk      (clk),
    .rst      (rst),
    .mode     (ct_mode),
    .load_val ('0),
    .fill     (core_dout),
    .q        (ct)
  );

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      core_rst <= 1'b1;
      core_key <= '0;
      core_din <= '0;
    end else begin
      done     <= 1'b0;
      core_key <= '0;
      core_din <= '0;
      cnt      <= (&cnt) ? cnt : cnt + CNT_W'(1);

      // The byte presented this cycle is the one the shifter drops.
      if (src_mode == SH_SHIFT) begin
        core_key <= key_q[BLOCK_W-1 -: BYTE_W];
        core_din <= pt_q[BLOCK_W-1 -: BYTE_W];
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= CRST;
            cnt   <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        CRST: begin
          state    <= GAP;
          cnt      <= '0;
          core_rst <= 1'b0;
        end
        GAP: begin
          if (gap_end) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (load_last) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (core_vld) begin
            state <= CAPT;
            cnt   <= '0;
          end else if (wait_to) begin
            state    <= IDLE;
            cnt      <= '0;
            err      <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
          end
        end
        CAPT: begin
          if (capt_last) begin
            state <= DONE;
            cnt   <= '0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          cnt      <= '0;
          busy     <= 1'b0;
          core_rst <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          busy     <= 1'b0;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_stream_ctrl.sv
// Directed self-checking bench for aes_byte_stream_ctrl with a behavioural
// core stub that records the load bytes and streams a programmed reply.
module tb_aes_byte_stream_ctrl;

  localparam int unsigned LD  = 4;
  localparam int unsigned TO  = 32;
  localparam int unsigned CW  = 11;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] REV_KEY  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SEQ_CT   = 128'h0102030405060708090a0b0c0d0e0f10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] pt;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] ct;
  logic         core_rst;
  logic [7:0]   core_key;
  logic [7:0]   core_din;
  logic [7:0]   core_dout;
  logic         core_vld;

  int checks = 0;
  int errors = 0;
  int idx    = 0;
  int done_cnt = 0;
  int at;
  int base;

  // Stub controls and records.
  logic [7:0] stream [16];
  logic [7:0] rec_key [16];
  logic [7:0] rec_din [16];
  int  stub_delay = 0;
  bit  stub_never = 1'b0;
  int  scyc;
  int  sidx;

  aes_byte_stream_ctrl #(
    .LOAD_DELAY (LD),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .pt        (pt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ct        (ct),
    .core_rst  (core_rst),
    .core_key  (core_key),
    .core_din  (core_din),
    .core_dout (core_dout),
    .core_vld  (core_vld)
  );

  always #5 clk = ~clk;

  initial begin
    assert (TO > 0 && TO < (1 << CW))
      else $fatal(1, "FAIL timeout_param TIMEOUT=%0d CNT_W=%0d", TO, CW);
  end

  // Core stub: counts cycles since core reset release, records the 16 load
  // bytes, then streams its reply; valid never drops until core reset.
  always @(posedge clk) begin
    if (core_rst) begin
      scyc      <= 0;
      sidx      <= 0;
      core_vld  <= 1'b0;
      core_dout <= 8'h00;
    end else begin
      scyc <= scyc + 1;
      if (scyc >= int'(LD) && scyc < int'(LD) + 16) begin
        rec_key[4'(scyc - int'(LD))] <= core_key;
        rec_din[4'(scyc - int'(LD))] <= core_din;
      end
      if (!stub_never && scyc >= int'(LD) + 15 + stub_delay && sidx < 16) begin
        core_vld  <= 1'b1;
        core_dout <= stream[4'(sidx)];
        sidx      <= sidx + 1;
      end
    end
  end

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog simulation did not finish");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic set_stream(input logic [127:0] v);
    for (int i = 0; i < 16; i++) stream[i] = v[127-8*i -: 8];
  endtask

  function automatic logic [127:0] flat(input logic [7:0] b [16]);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  // Index of the first cycle with done high, or -1 if the budget expires.
  task automatic wait_done(input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        when = idx;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {busy, done, err, core_rst, core_key, core_din}, {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
    chk({tag, "_ct"}, ct, 128'h0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    pt    = '0;
    set_stream(FIPS_CT);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // FIPS-197 block, reply 3 cycles into WAIT: done at 1+1+4+16+3+16 = 41.
    stub_delay = 3;
    key = FIPS_KEY;
    pt  = FIPS_PT;
    base = done_cnt;
    start = 1'b1;
    idx = 0;
    tick();
    start = 1'b0;
    key = '1;
    pt  = '1;
    chk("busy_after_start", 128'(busy), 128'(1));
    wait_done(200, at);
    chk("fips_latency", 128'(at), 128'(41));
    chk("fips_ct", ct, FIPS_CT);
    chk("fips_err", 128'(err), 128'(0));
    chk("fips_key_bytes", flat(rec_key), FIPS_KEY);
    chk("fips_pt_bytes", flat(rec_din), FIPS_PT);
    tick();
    chk("fips_done_once", 128'(done_cnt - base), 128'(1));
    chk("fips_idle", 128'({busy, done}), 128'(0));

    // Byte order and first-byte timing: first byte in cycle LD+2.
    stub_delay = 1;
    key = REV_KEY;
    pt  = FIPS_PT;
    start = 1'b1;
    idx = 0;
    tick();
    start = 1'b0;
    repeat (LD) tick();
    chk("order_before_first", 128'(core_key), 128'(0));
    tick();
    chk("order_first_byte", 128'(core_key), 128'h0f);
    wait_done(200, at);
    chk("order_latency", 128'(at), 128'(39));
    chk("order_key_seq", flat(rec_key), REV_KEY);
    tick();

    // Timeout: core never valid, err 32 cycles after WAIT entry (cycle 22).
    stub_never = 1'b1;
    base = done_cnt;
    start = 1'b1;
    idx = 0;
    tick();
    start = 1'b0;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (err) begin
        at = idx;
        break;
      end
    end
    chk("timeout_at", 128'(at), 128'(LD + 2 + 16 + TO));
    chk("timeout_state", 128'({busy, core_rst}), 128'(2'b01));
    tick();
    chk("timeout_sticky", 128'({err, busy}), 128'(2'b10));
    chk("timeout_no_done", 128'(done_cnt - base), 128'(0));

    // Start held high through the whole operation and the DONE cycle.
    stub_never = 1'b0;
    stub_delay = 0;
    key = FIPS_KEY;
    pt  = FIPS_PT;
    base = done_cnt;
    start = 1'b1;
    idx = 0;
    tick();
    chk("err_cleared_on_start", 128'(err), 128'(0));
    wait_done(200, at);
    chk("repeat_latency", 128'(at), 128'(38));
    tick();
    start = 1'b0;
    chk("done_cycle_start_ignored", 128'({busy, done}), 128'(0));
    chk("repeat_done_once", 128'(done_cnt - base), 128'(1));
    chk("repeat_ct", ct, FIPS_CT);

    // Second start: ct clears, immediate valid streams 01..10.
    set_stream(SEQ_CT);
    key = REV_KEY;
    start = 1'b1;
    idx = 0;
    tick();
    start = 1'b0;
    chk("ct_cleared", ct, 128'h0);
    wait_done(200, at);
    chk("immediate_latency", 128'(at), 128'(38));
    chk("immediate_ct", ct, SEQ_CT);
    tick();

    // Asynchronous reset during LOAD byte 7, then a clean FIPS run.
    set_stream(FIPS_CT);
    stub_delay = 2;
    key = FIPS_KEY;
    pt  = FIPS_PT;
    start = 1'b1;
    idx = 0;
    tick();
    start = 1'b0;
    while (idx < int'(LD) + 2 + 7) tick();
    chk("midrst_loading", 128'(core_key), 128'h07);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    idx = 0;
    tick();
    start = 1'b0;
    wait_done(200, at);
    chk("post_rst_latency", 128'(at), 128'(40));
    chk("post_rst_ct", ct, FIPS_CT);
    chk("post_rst_err", 128'(err), 128'(0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_byte_stream_ctrl.md
Name: aes_byte_stream_ctrl

Overview:
Wrapper-side controller that feeds the 8-bit serial AES core from 128-bit key and plaintext registers, then reassembles the 16 serial ciphertext bytes into a 128-bit result. It sits directly upstream of aes_8_bit (drives its rst, key_in and d_in) and directly downstream of it (consumes d_out and d_vld). The shell or register interface sees a single start/done handshake per block.

Parameters:
LOAD_DELAY, 4, idle cycles between core reset release and the first load byte; matches the core's load-entry wait.
TIMEOUT, 1024, maximum cycles in WAIT before aborting with err.
CNT_W, 11, width of the shared cycle counter; must hold TIMEOUT.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
key  in  128  cipher key; byte 15 is key[127:120], sent first
pt  in  128  plaintext; same byte order as key
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when ct is valid
err  out  1  sticky timeout flag; cleared by the next accepted start
ct  out  128  ciphertext; first captured byte goes to ct[127:120]
core_rst  out  1  drives the core's rst
core_key  out  8  drives the core's key_in
core_din  out  8  drives the core's d_in
core_dout  in  8  the core's d_out
core_vld  in  1  the core's d_vld

Behaviour:
- Reset values: busy 0, done 0, err 0, ct 0, core_rst 1, core_key 0, core_din 0, state IDLE, counter 0.
- key and pt are latched into shift registers on the accepted start. The caller may change them after that cycle.
- State machine:
  - IDLE: core_rst=1. On start, latch the inputs, clear err, go to CRST.
  - CRST: core_rst=1 for exactly one cycle, then go to GAP.
  - GAP: core_rst=0. Hold for LOAD_DELAY cycles, driving zeros, then go to LOAD.
  - LOAD: 16 consecutive cycles. Each cycle core_key and core_din present the top byte of their shift registers, then shift left by 8. Go to WAIT after byte 16.
  - WAIT: drive zeros and count cycles.
    - On the first cycle with core_vld=1, go to CAPT and capture core_dout in the same cycle as byte 0.
    - If the count reaches TIMEOUT, set err=1 and go to IDLE with no done pulse.
  - CAPT: shift core_dout into ct from the LSB side (ct <= {ct[119:0], core_dout}) for 15 more cycles. core_vld is not re-checked. Go to DONE after 16 total bytes.
  - DONE: pulse done=1 for one cycle, then go to IDLE.
- Latency from start to done = 1 + 1 + LOAD_DELAY + 16 + W + 16 cycles, where W is the WAIT dwell.
- ct holds its value until the next accepted start, then clears to 0.
- Counter: a single CNT_W-bit counter, cleared on every state transition. It saturates and never wraps.
- Boundary conditions:
  - start while busy: ignored, with no effect on the current operation.
  - start in the DONE cycle: ignored, because DONE is not IDLE.
  - core_vld already high on WAIT entry: capture begins that cycle.
  - rst asserted mid-operation: immediate return to reset values, and the core is held in reset.
  - TIMEOUT=0 is illegal; the bench checks it with an elaboration-time assertion.
  - The core's d_vld never drops without a core reset. The controller therefore holds the core in reset while idle, which guarantees a fresh rising edge on every operation.

Decomposition:
- Shared package aes_stream_pkg holds:
  - the state enum (IDLE, CRST, GAP, LOAD, WAIT, CAPT, DONE);
  - constants BLOCK_BYTES=16 and BYTE_W=8.
- One natural sub-module: aes_byte_shifter, a 128-bit register with load, shift-out-MSB and shift-in-LSB modes. It is instantiated three times: key, pt and ct.

Test Plan:
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, real core attached -> done pulses once; ct = 69c4e0d86a7b0430d8cdb78070b4c55a; err = 0.
- Byte order: key 0f0e...00, with a core stub that records its inputs -> core_key sequence starts 0f and ends 00; the first byte appears exactly LOAD_DELAY+2 cycles after start.
- Timeout: stub that never raises core_vld, TIMEOUT=32 -> err=1 exactly 32 cycles after WAIT entry; no done pulse; busy=0 on the next cycle.
- Repeated starts: start pulsed every cycle during an operation -> only one done pulse; a second start after done produces a correct second ct; ct clears to 0 on the second start.
- Mid-operation reset: rst asserted during LOAD byte 7 -> all outputs return to reset values asynchronously; a following start produces the correct FIPS-197 ct.
- Immediate valid: stub with core_vld already high when WAIT is entered, streaming bytes 01..10 -> ct = 0102030405060708090a0b0c0d0e0f10.
